// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the shared multi-cycle RV32I datapath: per-state
// datapath controls, memory handshake with timeout, halt detection and perf counters.
module multicycle_control_fsm #(
   parameter int CNT_W        = 32,
   parameter int MEM_WAIT_MAX = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       opcode,
   input  logic             halt_req,
   input  logic             alu_bcond,
   input  logic             mem_ready,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op_sel,
   output logic             pc_source,
   output logic             pc_write,
   output logic             is_halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] inst_count
);

   // state      | meaning
   // S_IF       | fetch: read mem at PC, latch IR on mem_ready
   // S_ID       | decode: ALUOut <= PC+4, dispatch on opcode
   // S_EX_R     | R-type ALU op rs1,rs2
   // S_EX_I     | I-type ALU op rs1,imm
   // S_EX_LS    | load/store address rs1+imm
   // S_MEM_RD   | data read at ALUOut
   // S_MEM_WR   | data write at ALUOut, retires on mem_ready
   // S_WB_ALU   | rd <= ALUOut, retire
   // S_WB_MEM   | rd <= mem data, retire
   // S_EX_JAL   | rd <= PC+4, PC <= PC+imm
   // S_EX_JALR  | rd <= PC+4, PC <= rs1+imm
   // S_EX_BR    | branch compare; not taken retires with PC+4
   // S_BR_TAKEN | PC <= PC+imm
   // S_PC_NEXT  | NOP / non-halting ECALL: PC <= PC+4
   // S_HALT     | absorbing until reset
   typedef enum logic [3:0] {
      S_IF, S_ID, S_EX_R, S_EX_I, S_EX_LS, S_MEM_RD, S_MEM_WR, S_WB_ALU,
      S_WB_MEM, S_EX_JAL, S_EX_JALR, S_EX_BR, S_BR_TAKEN, S_PC_NEXT, S_HALT
   } state_t;

   localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MEM_WAIT_MAX > 0) ? WAIT_W'(MEM_WAIT_MAX - 1) : '0;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                timeout_q, timeout_d;
   logic [CNT_W-1:0]    cycle_q, inst_q;
   logic                mem_state, wait_hit;

   logic                i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
   logic                reg_write_c, mem_to_reg_c, alu_src_a_c;
   logic [1:0]          alu_src_b_c, alu_op_sel_c;
   logic                pc_source_c, pc_write_c, is_halted_c;

   always_comb begin
      state_d   = state_q;
      timeout_d = timeout_q;
      mem_state = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
      case (state_q)
         S_IF:     if (mem_ready) state_d = S_ID;
         S_ID: begin
            case (opcode)
               7'b0110011: state_d = S_EX_R;
               7'b0010011: state_d = S_EX_I;
               7'b0000011,
               7'b0100011: state_d = S_EX_LS;
               7'b1100011: state_d = S_EX_BR;
               7'b1101111: state_d = S_EX_JAL;
               7'b1100111: state_d = S_EX_JALR;
               7'b1110011: state_d = halt_req ? S_HALT : S_PC_NEXT;
               default:    state_d = S_PC_NEXT;
            endcase
         end
         S_EX_R, S_EX_I: state_d = S_WB_ALU;
         S_EX_LS:  state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
         S_MEM_WR: if (mem_ready) state_d = S_IF;
         S_EX_BR:  state_d = alu_bcond ? S_BR_TAKEN : S_IF;
         S_WB_ALU, S_WB_MEM, S_EX_JAL, S_EX_JALR, S_BR_TAKEN, S_PC_NEXT:
                   state_d = S_IF;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IF;
      endcase
      // The current cycle is the MEM_WAIT_MAX-th consecutive stall cycle.
      wait_hit = (MEM_WAIT_MAX != 0) && mem_state && !mem_ready && (wait_q == WAIT_LAST);
      if (wait_hit) begin
         state_d   = S_HALT;
         timeout_d = 1'b1;
      end
      wait_d = (mem_state && !mem_ready && (state_d == state_q)) ? wait_q + 1'b1 : '0;
   end

   always_comb begin
      i_or_d_c     = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      mem_to_reg_c = 1'b0;
      alu_src_a_c  = 1'b0;
      alu_src_b_c  = 2'b00;
      alu_op_sel_c = 2'b00;
      pc_source_c  = 1'b0;
      pc_write_c   = 1'b0;
      is_halted_c  = 1'b0;
      case (state_q)
         S_IF: begin
            mem_read_c = 1'b1;
            ir_write_c = mem_ready;
         end
         S_ID:     alu_src_b_c = 2'b01;
         S_EX_R: begin
            alu_src_a_c  = 1'b1;
            alu_op_sel_c = 2'b01;
         end
         S_EX_I: begin
            alu_src_a_c  = 1'b1;
            alu_src_b_c  = 2'b10;
            alu_op_sel_c = 2'b01;
         end
         S_EX_LS: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
         end
         S_MEM_RD: begin
            i_or_d_c   = 1'b1;
            mem_read_c = 1'b1;
         end
         S_MEM_WR: begin
            i_or_d_c    = 1'b1;
            mem_write_c = 1'b1;
            if (mem_ready) begin
               alu_src_b_c = 2'b01;
               pc_write_c  = 1'b1;
            end
         end
         S_WB_ALU, S_WB_MEM: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = (state_q == S_WB_MEM);
            alu_src_b_c  = 2'b01;
            pc_write_c   = 1'b1;
         end
         S_EX_JAL, S_EX_JALR: begin
            reg_write_c = 1'b1;
            alu_src_a_c = (state_q == S_EX_JALR);
            alu_src_b_c = 2'b10;
            pc_write_c  = 1'b1;
         end
         S_EX_BR: begin
            alu_src_a_c  = 1'b1;
            alu_op_sel_c = 2'b10;
            if (!alu_bcond) begin
               pc_source_c = 1'b1;
               pc_write_c  = 1'b1;
            end
         end
         S_BR_TAKEN: begin
            alu_src_b_c = 2'b10;
            pc_write_c  = 1'b1;
         end
         S_PC_NEXT: begin
            pc_source_c = 1'b1;
            pc_write_c  = 1'b1;
         end
         S_HALT:   is_halted_c = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IF;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         cycle_q   <= '0;
         inst_q    <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         if (state_q != S_HALT) cycle_q <= cycle_q + CNT_W'(1);
         if (pc_write_c)        inst_q  <= inst_q + CNT_W'(1);
      end
   end

   // Reset forces every control low at once, even though the state is IF.
   assign i_or_d      = reset_n & i_or_d_c;
   assign mem_read    = reset_n & mem_read_c;
   assign mem_write   = reset_n & mem_write_c;
   assign ir_write    = reset_n & ir_write_c;
   assign reg_write   = reset_n & reg_write_c;
   assign mem_to_reg  = reset_n & mem_to_reg_c;
   assign alu_src_a   = reset_n & alu_src_a_c;
   assign alu_src_b   = reset_n ? alu_src_b_c  : 2'b00;
   assign alu_op_sel  = reset_n ? alu_op_sel_c : 2'b00;
   assign pc_source   = reset_n & pc_source_c;
   assign pc_write    = reset_n & pc_write_c;
   assign is_halted   = reset_n & is_halted_c;
   assign mem_timeout = timeout_q;
   assign cycle_count = cycle_q;
   assign inst_count  = inst_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle vector table of
// inputs and hand-computed controls/counters, plus reset and timeout sequences.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [6:0]  opcode;
   logic        halt_req, alu_bcond, mem_ready;
   logic        i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg;
   logic        alu_src_a, pc_source, pc_write, is_halted, mem_timeout;
   logic [1:0]  alu_src_b, alu_op_sel;
   logic [31:0] cycle_count, inst_count;

   int total = 0;
   int bad   = 0;

   multicycle_control_fsm #(.CNT_W(32), .MEM_WAIT_MAX(4)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .halt_req(halt_req),
      .alu_bcond(alu_bcond), .mem_ready(mem_ready), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel), .pc_source(pc_source),
      .pc_write(pc_write), .is_halted(is_halted), .mem_timeout(mem_timeout),
      .cycle_count(cycle_count), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   // {i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
   //  alu_src_a, alu_src_b[1:0], alu_op_sel[1:0], pc_source, pc_write, is_halted}
   logic [13:0] ctl;
   assign ctl = {i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op_sel, pc_source, pc_write, is_halted};

   localparam logic [13:0] K_ZERO = 14'b0_0_0_0_0_0_0_00_00_0_0_0;
   localparam logic [13:0] K_IF0  = 14'b0_1_0_0_0_0_0_00_00_0_0_0;
   localparam logic [13:0] K_IF1  = 14'b0_1_0_1_0_0_0_00_00_0_0_0;
   localparam logic [13:0] K_ID   = 14'b0_0_0_0_0_0_0_01_00_0_0_0;
   localparam logic [13:0] K_EXR  = 14'b0_0_0_0_0_0_1_00_01_0_0_0;
   localparam logic [13:0] K_EXI  = 14'b0_0_0_0_0_0_1_10_01_0_0_0;
   localparam logic [13:0] K_EXLS = 14'b0_0_0_0_0_0_1_10_00_0_0_0;
   localparam logic [13:0] K_MRD  = 14'b1_1_0_0_0_0_0_00_00_0_0_0;
   localparam logic [13:0] K_MWR0 = 14'b1_0_1_0_0_0_0_00_00_0_0_0;
   localparam logic [13:0] K_MWR1 = 14'b1_0_1_0_0_0_0_01_00_0_1_0;
   localparam logic [13:0] K_WBA  = 14'b0_0_0_0_1_0_0_01_00_0_1_0;
   localparam logic [13:0] K_WBM  = 14'b0_0_0_0_1_1_0_01_00_0_1_0;
   localparam logic [13:0] K_JAL  = 14'b0_0_0_0_1_0_0_10_00_0_1_0;
   localparam logic [13:0] K_JALR = 14'b0_0_0_0_1_0_1_10_00_0_1_0;
   localparam logic [13:0] K_BR0  = 14'b0_0_0_0_0_0_1_00_10_1_1_0;
   localparam logic [13:0] K_BR1  = 14'b0_0_0_0_0_0_1_00_10_0_0_0;
   localparam logic [13:0] K_BRT  = 14'b0_0_0_0_0_0_0_10_00_0_1_0;
   localparam logic [13:0] K_PCN  = 14'b0_0_0_0_0_0_0_00_00_1_1_0;
   localparam logic [13:0] K_HLT  = 14'b0_0_0_0_0_0_0_00_00_0_0_1;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_SYS  = 7'b1110011;

   typedef struct {
      logic [6:0]  op;
      logic        hr;
      logic        bc;
      logic        rdy;
      logic [13:0] ctl;
      int          cyc;
      int          inst;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [6:0] op, logic hr, logic bc, logic rdy,
                               logic [13:0] c, int cyc, int inst);
      vec_t v;
      v.op = op; v.hr = hr; v.bc = bc; v.rdy = rdy;
      v.ctl = c; v.cyc = cyc; v.inst = inst;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Entered and left at posedge+2; compares mid-cycle before the next edge.
   task automatic apply(vec_t v, string nm);
      opcode    = v.op;
      halt_req  = v.hr;
      alu_bcond = v.bc;
      mem_ready = v.rdy;
      #1;
      chk({nm, " ctl"},  {18'b0, ctl}, {18'b0, v.ctl});
      chk({nm, " cyc"},  cycle_count, v.cyc);
      chk({nm, " inst"}, inst_count,  v.inst);
      @(posedge clk);
      #2;
   endtask

   task automatic rst_pulse();
      reset_n = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; opcode = '0; halt_req = 0; alu_bcond = 0; mem_ready = 0;

      // R-type, branch both ways, load with stalls, store, jumps, I-type, NOP, halt
      tbl.push_back(mk(OP_R,   0,0,1, K_IF1, 0, 0));
      tbl.push_back(mk(OP_R,   0,0,1, K_ID,  1, 0));
      tbl.push_back(mk(OP_R,   0,0,1, K_EXR, 2, 0));
      tbl.push_back(mk(OP_R,   0,0,1, K_WBA, 3, 0));
      tbl.push_back(mk(OP_BR,  0,0,1, K_IF1, 4, 1));
      tbl.push_back(mk(OP_BR,  0,0,1, K_ID,  5, 1));
      tbl.push_back(mk(OP_BR,  0,0,1, K_BR0, 6, 1));
      tbl.push_back(mk(OP_BR,  0,1,1, K_IF1, 7, 2));
      tbl.push_back(mk(OP_BR,  0,1,1, K_ID,  8, 2));
      tbl.push_back(mk(OP_BR,  0,1,1, K_BR1, 9, 2));
      tbl.push_back(mk(OP_BR,  0,0,1, K_BRT,10, 2));
      tbl.push_back(mk(OP_LD,  0,0,1, K_IF1,11, 3));
      tbl.push_back(mk(OP_LD,  0,0,1, K_ID, 12, 3));
      tbl.push_back(mk(OP_LD,  0,0,1, K_EXLS,13,3));
      tbl.push_back(mk(OP_LD,  0,0,0, K_MRD,14, 3));
      tbl.push_back(mk(OP_LD,  0,0,0, K_MRD,15, 3));
      tbl.push_back(mk(OP_LD,  0,0,0, K_MRD,16, 3));
      tbl.push_back(mk(OP_LD,  0,0,1, K_MRD,17, 3));
      tbl.push_back(mk(OP_LD,  0,0,1, K_WBM,18, 3));
      tbl.push_back(mk(OP_ST,  0,0,1, K_IF1,19, 4));
      tbl.push_back(mk(OP_ST,  0,0,1, K_ID, 20, 4));
      tbl.push_back(mk(OP_ST,  0,0,1, K_EXLS,21,4));
      tbl.push_back(mk(OP_ST,  0,0,0, K_MWR0,22,4));
      tbl.push_back(mk(OP_ST,  0,0,1, K_MWR1,23,4));
      tbl.push_back(mk(OP_JAL, 0,0,1, K_IF1,24, 5));
      tbl.push_back(mk(OP_JAL, 0,0,1, K_ID, 25, 5));
      tbl.push_back(mk(OP_JAL, 0,0,1, K_JAL,26, 5));
      tbl.push_back(mk(OP_JALR,0,0,1, K_IF1,27, 6));
      tbl.push_back(mk(OP_JALR,0,0,1, K_ID, 28, 6));
      tbl.push_back(mk(OP_JALR,0,0,1, K_JALR,29,6));
      tbl.push_back(mk(OP_I,   0,0,1, K_IF1,30, 7));
      tbl.push_back(mk(OP_I,   0,0,1, K_ID, 31, 7));
      tbl.push_back(mk(OP_I,   0,0,1, K_EXI,32, 7));
      tbl.push_back(mk(OP_I,   0,0,1, K_WBA,33, 7));
      tbl.push_back(mk(OP_SYS, 0,0,1, K_IF1,34, 8));
      tbl.push_back(mk(OP_SYS, 0,0,1, K_ID, 35, 8));
      tbl.push_back(mk(OP_SYS, 0,0,1, K_PCN,36, 8));
      tbl.push_back(mk(7'h7F,  0,0,1, K_IF1,37, 9));
      tbl.push_back(mk(7'h7F,  0,0,1, K_ID, 38, 9));
      tbl.push_back(mk(7'h7F,  0,0,1, K_PCN,39, 9));
      tbl.push_back(mk(OP_SYS, 1,0,1, K_IF1,40,10));
      tbl.push_back(mk(OP_SYS, 1,0,1, K_ID, 41,10));
      tbl.push_back(mk(OP_R,   0,0,1, K_HLT,42,10));
      tbl.push_back(mk(OP_R,   0,1,1, K_HLT,42,10));
      tbl.push_back(mk(OP_LD,  0,0,0, K_HLT,42,10));

      #3;
      chk("reset ctl",  {18'b0, ctl}, {18'b0, K_ZERO});
      chk("reset tmo",  {31'b0, mem_timeout}, 32'd0);
      chk("reset cyc",  cycle_count, 32'd0);
      chk("reset inst", inst_count, 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));
      chk("ecall halt tmo", {31'b0, mem_timeout}, 32'd0);

      // Reset mid-store abandons the write immediately; NOP opcode afterwards
      rst_pulse();
      apply(mk(OP_ST, 0,0,1, K_IF1, 0,0), "t6 if");
      apply(mk(OP_ST, 0,0,1, K_ID,  1,0), "t6 id");
      apply(mk(OP_ST, 0,0,1, K_EXLS,2,0), "t6 ex");
      apply(mk(OP_ST, 0,0,0, K_MWR0,3,0), "t6 wr0");
      #1;
      chk("t6 wr held", {18'b0, ctl}, {18'b0, K_MWR0});
      reset_n = 1'b0;
      #1;
      chk("t6 rst mem_write", {31'b0, mem_write}, 32'd0);
      chk("t6 rst ctl", {18'b0, ctl}, {18'b0, K_ZERO});
      chk("t6 rst cyc", cycle_count, 32'd0);
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      apply(mk(7'h00, 0,0,1, K_IF1, 0,0), "t6 nop if");
      apply(mk(7'h00, 0,0,1, K_ID,  1,0), "t6 nop id");
      apply(mk(7'h00, 0,0,1, K_PCN, 2,0), "t6 nop pcn");
      apply(mk(OP_R,  0,0,1, K_IF1, 3,1), "t6 nop done");

      // Fetch stalled forever: timeout halt on the 4th wait cycle
      rst_pulse();
      apply(mk(OP_R, 0,0,0, K_IF0, 0,0), "t5 w1");
      apply(mk(OP_R, 0,0,0, K_IF0, 1,0), "t5 w2");
      apply(mk(OP_R, 0,0,0, K_IF0, 2,0), "t5 w3");
      #1;
      chk("t5 tmo before", {31'b0, mem_timeout}, 32'd0);
      apply(mk(OP_R, 0,0,0, K_IF0, 3,0), "t5 w4");
      apply(mk(OP_R, 0,0,0, K_HLT, 4,0), "t5 halt");
      chk("t5 tmo", {31'b0, mem_timeout}, 32'd1);
      apply(mk(OP_R, 0,0,1, K_HLT, 4,0), "t5 frozen");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
